// File: rtl/dds_pinc_hls_deadlock_collector.sv
// Deadlock report collector for the dds_pinc HLS wrapper monitors: qualifies a held `block`, reports it once.
// Optional: define DDS_PINC_DEADLOCK_AUTOREARM_EN to return to IDLE after each accepted report.
module dds_pinc_hls_deadlock_collector #(
    parameter int unsigned NUM_MON     = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] block_in,
    input  logic               clear,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [IDX_W-1:0]   report_idx,
    output logic [CNT_W-1:0]   report_ts,
    output logic               deadlock
);

    localparam int unsigned PAD_W = 1 << IDX_W;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_REPORT,
        S_LATCHED
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] ts_cnt;
    logic [CNT_W-1:0] cand_ts;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_next;
    logic [CNT_W-1:0] report_ts_q;
    logic [IDX_W-1:0] cand_idx;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] report_idx_q;
    logic [PAD_W-1:0] block_pad;
    logic             any_block;
    logic             cand_block;
    logic             load_cand;
    logic             load_report;
    logic             deadlock_q;
    logic             deadlock_next;

    // Pad to the full index range so a candidate index never selects outside the vector.
    always_comb begin
        block_pad = '0;
        block_pad[NUM_MON-1:0] = block_in;
        first_idx = '0;
        any_block = 1'b0;
        for (int unsigned i = 0; i < NUM_MON; i++) begin
            if (block_in[i] && !any_block) begin
                first_idx = IDX_W'(i);
                any_block = 1'b1;
            end
        end
    end

    assign cand_block = block_pad[cand_idx];

    always_comb begin
        state_next    = state;
        hold_next     = hold_cnt;
        load_cand     = 1'b0;
        load_report   = 1'b0;
        deadlock_next = deadlock_q;
        if (clear) begin
            state_next    = S_IDLE;
            hold_next     = '0;
            deadlock_next = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_block) begin
                        load_cand  = 1'b1;
                        hold_next  = CNT_W'(1);
                        state_next = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (!cand_block) begin
                        hold_next  = '0;
                        state_next = S_IDLE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        load_report   = 1'b1;
                        deadlock_next = 1'b1;
                        state_next    = S_REPORT;
                    end else begin
                        hold_next = hold_cnt + CNT_W'(1);
                    end
                end
                S_REPORT: begin
                    if (report_ready) begin
`ifdef DDS_PINC_DEADLOCK_AUTOREARM_EN
                        state_next = S_IDLE;
`else
                        state_next = S_LATCHED;
`endif
                    end
                end
                S_LATCHED: begin
                    state_next = S_LATCHED;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            ts_cnt       <= '0;
            hold_cnt     <= '0;
            cand_idx     <= '0;
            cand_ts      <= '0;
            report_idx_q <= '0;
            report_ts_q  <= '0;
            deadlock_q   <= 1'b0;
        end else begin
            state      <= state_next;
            ts_cnt     <= ts_cnt + CNT_W'(1);
            hold_cnt   <= hold_next;
            deadlock_q <= deadlock_next;
            if (load_cand) begin
                cand_idx <= first_idx;
                cand_ts  <= ts_cnt;
            end
            if (load_report) begin
                report_idx_q <= cand_idx;
                report_ts_q  <= cand_ts;
            end
        end
    end

    assign report_valid = (state == S_REPORT);
    assign report_idx   = report_idx_q;
    assign report_ts    = report_ts_q;
    assign deadlock     = deadlock_q;

endmodule

// File: tb/tb_dds_pinc_hls_deadlock_collector.sv
// Directed bench for dds_pinc_hls_deadlock_collector: qualification, glitch, priority, backpressure, clear, reset, wrap.
module tb_dds_pinc_hls_deadlock_collector;

    logic        clock;
    logic        reset;
    logic [3:0]  block_in;
    logic        clear;
    logic        report_valid;
    logic        report_ready;
    logic [1:0]  report_idx;
    logic [15:0] report_ts;
    logic        deadlock;

    logic [3:0]  block_w;
    logic        valid_w;
    logic [1:0]  idx_w;
    logic [3:0]  ts_w;
    logic        deadlock_w;

    logic [15:0] tb_ts;
    logic [15:0] exp_ts;
    int unsigned n_checks;
    int unsigned n_errors;

    dds_pinc_hls_deadlock_collector #(
        .NUM_MON(4), .IDX_W(2), .HOLD_CYCLES(16), .CNT_W(16)
    ) u_dut (
        .clock(clock), .reset(reset), .block_in(block_in), .clear(clear),
        .report_valid(report_valid), .report_ready(report_ready),
        .report_idx(report_idx), .report_ts(report_ts), .deadlock(deadlock)
    );

    dds_pinc_hls_deadlock_collector #(
        .NUM_MON(4), .IDX_W(2), .HOLD_CYCLES(4), .CNT_W(4)
    ) u_wrap (
        .clock(clock), .reset(reset), .block_in(block_w), .clear(1'b0),
        .report_valid(valid_w), .report_ready(1'b1),
        .report_idx(idx_w), .report_ts(ts_w), .deadlock(deadlock_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference timestamp: the value the DUT counter holds between edges.
    always @(posedge clock) begin
        if (reset) tb_ts <= '0;
        else       tb_ts <= tb_ts + 16'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic expect_quiet(input int unsigned n, input string tag);
        for (int unsigned i = 0; i < n; i++) begin
            step();
            check(tag, 32'(report_valid), 32'd0);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        bit aligned;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        block_in = '0;
        block_w = '0;
        clear = 1'b0;
        report_ready = 1'b1;
        repeat (3) step();
        check("rst_valid", 32'(report_valid), 32'd0);
        check("rst_idx", 32'(report_idx), 32'd0);
        check("rst_ts", 32'(report_ts), 32'd0);
        check("rst_deadlock", 32'(deadlock), 32'd0);
        check("rst_valid_w", 32'(valid_w), 32'd0);
        reset = 1'b0;
        repeat (10) step();

        // Qualification on monitor 2
        block_in = 4'b0100;
        exp_ts = tb_ts;
        expect_quiet(15, "q1_wait");
        step();
        check("q1_valid", 32'(report_valid), 32'd1);
        check("q1_idx", 32'(report_idx), 32'd2);
        check("q1_ts", 32'(report_ts), 32'(exp_ts));
        check("q1_deadlock", 32'(deadlock), 32'd1);
        step();
        check("q1_valid_drop", 32'(report_valid), 32'd0);
`ifdef DDS_PINC_DEADLOCK_AUTOREARM_EN
        exp_ts = tb_ts;
        expect_quiet(15, "q2_wait");
        step();
        check("q2_valid", 32'(report_valid), 32'd1);
        check("q2_ts", 32'(report_ts), 32'(exp_ts));
        check("q2_deadlock", 32'(deadlock), 32'd1);
        step();
        check("q2_valid_drop", 32'(report_valid), 32'd0);
`else
        expect_quiet(20, "latched_ignore");
        check("latched_deadlock", 32'(deadlock), 32'd1);
`endif
        block_in = 4'b0000;
        pulse_clear();
        check("clr1_deadlock", 32'(deadlock), 32'd0);
        check("clr1_valid", 32'(report_valid), 32'd0);
        repeat (2) step();

        // Glitch: 15 high samples do not qualify
        block_in = 4'b0010;
        expect_quiet(15, "glitch_wait");
        block_in = 4'b0000;
        step();
        check("glitch_valid", 32'(report_valid), 32'd0);
        check("glitch_deadlock", 32'(deadlock), 32'd0);
        block_in = 4'b0010;
        exp_ts = tb_ts;
        expect_quiet(15, "run2_wait");
        step();
        check("run2_valid", 32'(report_valid), 32'd1);
        check("run2_idx", 32'(report_idx), 32'd1);
        check("run2_ts", 32'(report_ts), 32'(exp_ts));

        // Backpressure then clear with ready high
        report_ready = 1'b0;
        for (int unsigned i = 0; i < 20; i++) begin
            step();
            check("bp_valid", 32'(report_valid), 32'd1);
            check("bp_idx", 32'(report_idx), 32'd1);
            check("bp_ts", 32'(report_ts), 32'(exp_ts));
        end
        report_ready = 1'b1;
        block_in = 4'b0000;
        pulse_clear();
        check("abort_valid", 32'(report_valid), 32'd0);
        check("abort_deadlock", 32'(deadlock), 32'd0);
        expect_quiet(5, "abort_quiet");

        // Simultaneous rise: lowest index wins, bit 3 toggling ignored
        block_in = 4'b1010;
        exp_ts = tb_ts;
        step();
        check("sim_first", 32'(report_valid), 32'd0);
        for (int unsigned i = 0; i < 14; i++) begin
            block_in = (i % 2 == 0) ? 4'b0010 : 4'b1010;
            step();
            check("sim_wait", 32'(report_valid), 32'd0);
        end
        step();
        check("sim_valid", 32'(report_valid), 32'd1);
        check("sim_idx", 32'(report_idx), 32'd1);
        check("sim_ts", 32'(report_ts), 32'(exp_ts));
        step();
        block_in = 4'b0000;
        pulse_clear();
        check("sim_clr", 32'(deadlock), 32'd0);

        // Reset mid-ARMED
        block_in = 4'b0001;
        repeat (8) step();
        reset = 1'b1;
        step();
        check("rst2_valid", 32'(report_valid), 32'd0);
        check("rst2_idx", 32'(report_idx), 32'd0);
        check("rst2_ts", 32'(report_ts), 32'd0);
        check("rst2_deadlock", 32'(deadlock), 32'd0);
        reset = 1'b0;
        block_in = 4'b0000;
        expect_quiet(20, "rst2_quiet");
        check("rst2_deadlock_after", 32'(deadlock), 32'd0);

        // Timestamp wrap on the 4-bit instance
        aligned = 1'b0;
        for (int unsigned i = 0; i < 20 && !aligned; i++) begin
            if (tb_ts[3:0] == 4'd15) aligned = 1'b1;
            else step();
        end
        check("wrap_align", 32'(aligned), 32'd1);
        block_w = 4'b0100;
        repeat (3) begin
            step();
            check("wrap_wait", 32'(valid_w), 32'd0);
        end
        step();
        check("wrap_valid", 32'(valid_w), 32'd1);
        check("wrap_idx", 32'(idx_w), 32'd2);
        check("wrap_ts", 32'(ts_w), 32'd15);
        check("wrap_deadlock", 32'(deadlock_w), 32'd1);
        block_w = 4'b0000;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
